// File: rtl/run_monitor_pkg.sv
// Shared types for the run-completion watchdog: FSM state encoding, terminal
// status flags and the width helper for the hung-hart index.
package run_monitor_pkg;

   localparam int unsigned StateW = 3;

   typedef enum logic [StateW-1:0] {
      StIdle    = 3'd0,
      StRun     = 3'd1,
      StDrain   = 3'd2,
      StPass    = 3'd3,
      StTimeout = 3'd4,
      StHang    = 3'd5
   } state_e;

   // Sticky terminal flags, one per terminal state.
   typedef struct packed {
      logic pass;
      logic timeout;
      logic hang;
   } status_t;

   localparam status_t StatusNone = '0;

   // Index width for a hart number; a single hart still gets one bit.
   function automatic int unsigned hart_idx_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/hang_counter.sv
// Per-hart forward-progress counter. Counts idle cycles, saturates at Limit and
// raises tc_o while the count sits one short of the hang window.
module hang_counter #(
   parameter int unsigned Limit = 1024
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic clr_i,
   input  logic inc_i,
   output logic tc_o
);

   localparam int unsigned CntW = (Limit > 1) ? $clog2(Limit + 1) : 1;
   localparam logic [CntW-1:0] CntMax = CntW'(Limit);
   localparam logic [CntW-1:0] CntLast = CntW'((Limit > 0) ? Limit - 1 : 0);

   logic [CntW-1:0] cnt_q, cnt_d;

   // Next count: clear wins, otherwise saturating increment (Limit 0 disables counting)
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && (Limit != 0) && (cnt_q != CntMax)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Count register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tc_o = (Limit != 0) && (cnt_q == CntLast);

endmodule

// File: rtl/run_monitor.sv
// Run-completion watchdog: waits for every hart to report done, then drains for
// a fixed window before declaring pass. Flags a global cycle timeout or a hart
// that stops retiring. All outputs come straight from registers.
module run_monitor
   import run_monitor_pkg::*;
#(
   parameter int unsigned NUM_HARTS      = 1,
   parameter int unsigned XLEN           = 32,
   parameter int unsigned TIMEOUT_CYCLES = 200000,
   parameter int unsigned DRAIN_CYCLES   = 20,
   parameter int unsigned HANG_CYCLES    = 1024,
   parameter int unsigned CNT_W          = 32
) (
   input  logic                              clk,
   input  logic                              reset_n,
   input  logic                              start,
   input  logic                              clear,
   input  logic [NUM_HARTS-1:0]              done_i,
   input  logic [NUM_HARTS-1:0]              retire_valid_i,
   input  logic [NUM_HARTS*XLEN-1:0]         pc_i,
   output logic [StateW-1:0]                 state_o,
   output logic                              busy_o,
   output logic                              finished_o,
   output logic                              pass_o,
   output logic                              timeout_o,
   output logic                              hang_o,
   output logic [NUM_HARTS-1:0]              done_mask_o,
   output logic [hart_idx_w(NUM_HARTS)-1:0]  hang_hart_o,
   output logic [XLEN-1:0]                   hang_pc_o,
   output logic [CNT_W-1:0]                  cycle_cnt_o
);

   localparam int unsigned HartW = hart_idx_w(NUM_HARTS);
   localparam int unsigned DrainW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
   localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [DrainW-1:0] DrainLast =
      DrainW'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);

   state_e               state_q;
   status_t              status_q;
   logic                 busy_q;
   logic                 finished_q;
   logic [NUM_HARTS-1:0] done_mask_q;
   logic [HartW-1:0]     hang_hart_q;
   logic [XLEN-1:0]      hang_pc_q;
   logic [CNT_W-1:0]     cycle_cnt_q;
   logic [DrainW-1:0]    drain_q;

   logic                 in_run;
   logic                 run_entry;
   logic                 all_done;
   logic [NUM_HARTS-1:0] done_seen;
   logic [NUM_HARTS-1:0] hc_clr;
   logic [NUM_HARTS-1:0] hc_inc;
   logic [NUM_HARTS-1:0] hc_tc;
   logic [NUM_HARTS-1:0] hang_hit;
   logic                 hang_any;
   logic [HartW-1:0]     hang_idx;
   logic [XLEN-1:0]      hang_pc;
   logic [CNT_W-1:0]     cycle_cnt_inc;

   assign in_run    = (state_q == StRun);
   assign run_entry = (state_q == StIdle) && start && !clear;
   assign done_seen = done_mask_q | done_i;
   assign all_done  = &done_seen;

   // A hart is making progress if it retires or has finished; counters only move in RUN.
   assign hc_clr   = {NUM_HARTS{run_entry}} | ({NUM_HARTS{in_run}} & (retire_valid_i | done_seen));
   assign hc_inc   = {NUM_HARTS{in_run}} & ~(retire_valid_i | done_seen);
   assign hang_hit = hc_tc & ~retire_valid_i;

   assign cycle_cnt_inc = (&cycle_cnt_q) ? cycle_cnt_q : cycle_cnt_q + 1'b1;

   for (genvar h = 0; h < NUM_HARTS; h++) begin : g_hang
      hang_counter #(
         .Limit (HANG_CYCLES)
      ) u_hang_counter (
         .clk_i  (clk),
         .rst_ni (reset_n),
         .clr_i  (hc_clr[h]),
         .inc_i  (hc_inc[h]),
         .tc_o   (hc_tc[h])
      );
   end

   // Lowest-index hung hart and its PC; scanning downward lets the lowest hit win
   always_comb begin
      hang_any = 1'b0;
      hang_idx = '0;
      hang_pc  = '0;
      for (int h = NUM_HARTS - 1; h >= 0; h--) begin
         if (hang_hit[h]) begin
            hang_any = 1'b1;
            hang_idx = HartW'(h);
            hang_pc  = pc_i[h*XLEN +: XLEN];
         end
      end
   end

   // Controller: state, sticky flags, capture registers and the RUN+DRAIN cycle counter
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= StIdle;
         status_q    <= StatusNone;
         busy_q      <= 1'b0;
         finished_q  <= 1'b0;
         done_mask_q <= '0;
         hang_hart_q <= '0;
         hang_pc_q   <= '0;
         cycle_cnt_q <= '0;
         drain_q     <= '0;
      end else begin
         finished_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (run_entry) begin
                  state_q     <= StRun;
                  busy_q      <= 1'b1;
                  status_q    <= StatusNone;
                  done_mask_q <= '0;
                  hang_hart_q <= '0;
                  hang_pc_q   <= '0;
                  cycle_cnt_q <= '0;
               end
            end
            StRun: begin
               if (clear) begin
                  state_q     <= StIdle;
                  busy_q      <= 1'b0;
                  done_mask_q <= '0;
               end else begin
                  cycle_cnt_q <= cycle_cnt_inc;
                  done_mask_q <= done_seen;
                  // Completion outranks timeout, which outranks hang
                  if (all_done) begin
                     if (DRAIN_CYCLES == 0) begin
                        state_q         <= StPass;
                        busy_q          <= 1'b0;
                        finished_q      <= 1'b1;
                        status_q.pass   <= 1'b1;
                     end else begin
                        state_q <= StDrain;
                        drain_q <= '0;
                     end
                  end else if (cycle_cnt_q == TimeoutLast) begin
                     state_q          <= StTimeout;
                     busy_q           <= 1'b0;
                     finished_q       <= 1'b1;
                     status_q.timeout <= 1'b1;
                  end else if (hang_any) begin
                     state_q       <= StHang;
                     busy_q        <= 1'b0;
                     finished_q    <= 1'b1;
                     status_q.hang <= 1'b1;
                     hang_hart_q   <= hang_idx;
                     hang_pc_q     <= hang_pc;
                  end
               end
            end
            StDrain: begin
               if (clear) begin
                  state_q     <= StIdle;
                  busy_q      <= 1'b0;
                  done_mask_q <= '0;
               end else begin
                  cycle_cnt_q <= cycle_cnt_inc;
                  if (drain_q == DrainLast) begin
                     state_q       <= StPass;
                     busy_q        <= 1'b0;
                     finished_q    <= 1'b1;
                     status_q.pass <= 1'b1;
                  end else begin
                     drain_q <= drain_q + 1'b1;
                  end
               end
            end
            StPass, StTimeout, StHang: begin
               if (clear) begin
                  state_q     <= StIdle;
                  status_q    <= StatusNone;
                  done_mask_q <= '0;
                  hang_hart_q <= '0;
                  hang_pc_q   <= '0;
               end
            end
            default: begin
               state_q <= StIdle;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign state_o     = state_q;
   assign busy_o      = busy_q;
   assign finished_o  = finished_q;
   assign pass_o      = status_q.pass;
   assign timeout_o   = status_q.timeout;
   assign hang_o      = status_q.hang;
   assign done_mask_o = done_mask_q;
   assign hang_hart_o = hang_hart_q;
   assign hang_pc_o   = hang_pc_q;
   assign cycle_cnt_o = cycle_cnt_q;

endmodule

// File: doc/run_monitor.md
# run_monitor

Synthesizable run-completion watchdog for multi-hart RV32IM simulation and FPGA bring-up. Each hart reports done, retire and PC. The block runs a state machine that detects completion of all harts, enforces a global cycle timeout, and detects per-hart forward-progress hangs. After completion it holds off a parametrised drain window before declaring pass. It sits beside the processor top and replaces ad-hoc bench timeouts with a parametrised, checkable status source.

## Interface
- NUM_HARTS, 1: number of monitored harts (1..8).
- XLEN, 32: PC width per hart.
- TIMEOUT_CYCLES, 200000: global cycle budget in RUN; must be ≥1.
- DRAIN_CYCLES, 20: cycles spent in DRAIN before PASS; 0 allowed.
- HANG_CYCLES, 1024: consecutive non-retiring cycles that flag a hang; 0 disables hang detection.
- CNT_W, 32: width of the cycle counter.

- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  pulse; accepted only in IDLE
- clear  in  1  pulse; returns any terminal state to IDLE
- done_i  in  NUM_HARTS  per-hart done level
- retire_valid_i  in  NUM_HARTS  per-hart instruction-retired strobe
- pc_i  in  NUM_HARTS*XLEN  per-hart PC; hart h occupies bits [h*XLEN +: XLEN]
- state_o  out  3  encoded state
- busy_o  out  1  high in RUN or DRAIN
- finished_o  out  1  one-cycle pulse on entry to any terminal state
- pass_o, timeout_o, hang_o  out  1 each  sticky terminal flags
- done_mask_o  out  NUM_HARTS  captured done bits
- hang_hart_o  out  max(1,$clog2(NUM_HARTS))  lowest-index hart that hung
- hang_pc_o  out  XLEN  that hart's pc_i at the hang detection cycle
- cycle_cnt_o  out  CNT_W  cycles spent in RUN plus DRAIN

## Operation
- States: IDLE=0, RUN=1, DRAIN=2, PASS=3, TIMEOUT=4, HANG=5.
- Reset values: state IDLE. All outputs are 0.
- IDLE:
  - start=1 → RUN next cycle.
  - Entry into RUN zeroes cycle_cnt, done_mask, the hang counters and the flags.
- RUN:
  - done_mask |= done_i every cycle.
  - all_done = &(done_mask | done_i).
  - Per-hart hang counter: resets to 0 on retire_valid_i[h] or when hart h is done; otherwise increments and saturates at HANG_CYCLES.
  - Transitions are evaluated per cycle, in this priority order:
    1. all_done → DRAIN, or → PASS if DRAIN_CYCLES=0.
    2. cycle_cnt==TIMEOUT_CYCLES-1 → TIMEOUT.
    3. Any hang counter ==HANG_CYCLES-1 with no retire that cycle, and HANG_CYCLES≠0 → HANG.
- DRAIN:
  - Lasts exactly DRAIN_CYCLES cycles, then → PASS.
  - Timeout and hang are not evaluated in DRAIN.
  - done_i deasserting in DRAIN is ignored.
- Terminal states (PASS, TIMEOUT, HANG):
  - The matching flag is held; cycle_cnt freezes.
  - clear → IDLE; flags and done_mask return to 0.
  - start is ignored in terminal states.
- clear in RUN or DRAIN aborts to IDLE. No flag is set and finished_o does not pulse.
- start and clear in the same cycle: clear wins.
- cycle_cnt saturates at all-ones; it never wraps.

## Timing
- Every output is registered. The state_o change is visible the cycle after the deciding input edge.
- finished_o is high exactly in the first cycle of a terminal state.
- Start-to-PASS latency with all harts already done at the first RUN cycle: 1 (RUN) + DRAIN_CYCLES + 1.
- TIMEOUT is entered after exactly TIMEOUT_CYCLES RUN cycles; cycle_cnt_o then reads TIMEOUT_CYCLES.
- Asserting reset_n low mid-run forces IDLE immediately and clears every output, independent of clk.

## Structure
- Package run_monitor_pkg holds:
  - the state enum/localparams;
  - the status encoding;
  - a helper function for the hang_hart index width.
- One sub-module, hang_counter: a per-hart saturating counter with a clear input and a terminal-count output.
- run_monitor instantiates NUM_HARTS copies of hang_counter via generate. It also contains:
  - the FSM;
  - the cycle counter;
  - the lowest-index priority encoder for the hang report.

## Test plan
- NUM_HARTS=2, DRAIN_CYCLES=20. start; hart0 done at cycle 10, hart1 done at cycle 30 (levels dropping later) → DRAIN at cycle 31, PASS 20 cycles later, finished_o pulses once, done_mask_o=2'b11.
- TIMEOUT_CYCLES=100, no done → TIMEOUT after 100 RUN cycles, cycle_cnt_o=100, timeout_o=1, pass_o=0.
- HANG_CYCLES=16; hart1 stops retiring at PC 0x0000_0040 while hart0 keeps retiring → HANG after 16 idle cycles, hang_hart_o=1, hang_pc_o=0x40.
- all_done and the timeout condition in the same cycle → DRAIN taken, no timeout flag. DRAIN_CYCLES=0 variant → PASS directly the next cycle.
- reset_n low for 3 ns mid-DRAIN → IDLE asynchronously, all outputs 0. clear during RUN → IDLE with no finished_o pulse.
- Terminal-state handling, from PASS:
  - start is ignored.
  - clear → IDLE.
  - A new start then re-runs with cycle_cnt_o restarted from 0.
